// File: rtl/mips_mem_responder.sv
// mips_mem_responder: single-port word RAM behind a MIPS-style
// read/write/waitrequest bus. One transfer in flight at a time; each
// transfer spends one accept cycle plus LATENCY wait cycles before a
// one-cycle response. Out-of-range accesses, conflicting requests and
// requests that change mid-transfer raise a sticky err flag.
//
// Handshake: the CPU holds read or write (exactly one), address,
// byteenable and writedata stable while waitrequest is high. The
// transfer completes in the cycle where waitrequest is low with the
// request still present (the RESP cycle). Read data is valid in that
// cycle and holds afterwards. Write data lands in memory at the edge
// that ends the RESP cycle.
module mips_mem_responder #(
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'hBFC00000,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    input  logic        stall,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err,
    output logic [1:0]  state_dbg
);

    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [29:0]   lat_addr;
    logic [3:0]    lat_be;
    logic [31:0]   lat_data;
    logic          lat_read;
    logic          lat_write;
    logic          lat_in_range;
    logic [AW-1:0] lat_idx;

    // Contents survive reset; they start out as all zeros.
    logic [31:0]   mem [DEPTH] = '{default: 32'h0};

    logic          req_one;
    logic          addr_in_range;
    logic [AW-1:0] addr_idx;
    logic          req_changed;
    logic          addr_lsb_unused;

    // Byte offset bits of the address play no part in word addressing.
    assign addr_lsb_unused = ^address[1:0];

    // Request decode, range check and word index of the presented address.
    always_comb begin
        req_one       = read ^ write;
        addr_in_range = ({1'b0, address} >= {1'b0, BASE}) && ({1'b0, address} < LIMIT);
        // Only the low index bits matter once the range check has passed.
        addr_idx      = address[AW+1:2] - BASE[AW+1:2];
        // Any deviation from the latched request (including both ops low
        // or both high) means the CPU abandoned the transfer.
        req_changed   = (address[31:2] != lat_addr) || (read != lat_read) ||
                        (write != lat_write) || (byteenable != lat_be);
    end

    // Wait is asserted while a request sits in IDLE and for all of WAIT.
    always_comb begin
        waitrequest = (state == WAIT) || ((state == IDLE) && req_one);
        state_dbg   = state;
    end

    // Transfer sequencing, read data capture and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            readdata     <= 32'h0;
            err          <= 1'b0;
            lat_addr     <= 30'h0;
            lat_be       <= 4'h0;
            lat_data     <= 32'h0;
            lat_read     <= 1'b0;
            lat_write    <= 1'b0;
            lat_in_range <= 1'b0;
            lat_idx      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read && write) begin
                        err <= 1'b1;
                    end else if (req_one) begin
                        lat_addr     <= address[31:2];
                        lat_be       <= byteenable;
                        lat_data     <= writedata;
                        lat_read     <= read;
                        lat_write    <= write;
                        lat_in_range <= addr_in_range;
                        lat_idx      <= addr_idx;
                        cnt          <= 4'(LATENCY - 1);
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (req_changed) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (cnt == 4'd0) begin
                        // Stall only lengthens the final wait cycle.
                        if (!stall) begin
                            state <= RESP;
                            if (!lat_in_range) begin
                                err <= 1'b1;
                            end
                            if (lat_read) begin
                                readdata <= lat_in_range ? mem[lat_idx] : 32'h0;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write commit at the edge ending RESP; reset at that edge drops it.
    always_ff @(posedge clk) begin
        if (rst_n && (state == RESP) && lat_write && lat_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder. A transaction-level model of the
// memory, read data register and error flag predicts, cycle by cycle, the
// waitrequest/err/readdata values; one compare process checks them on
// every falling edge. Literal expectations pin the model on key cases.
module tb_mips_mem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        stall;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        err;
    logic [1:0]  state_dbg;

    mips_mem_responder #(
        .DEPTH   (DEPTH),
        .BASE    (BASE),
        .LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .stall       (stall),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model and scoreboard ----------------
    logic [31:0] mem_m [DEPTH];
    logic [31:0] rd_m;
    logic        err_m;
    logic [33:0] exp_q[$];   // {waitrequest, err, readdata} per cycle
    int          total;
    int          bad;
    int          run_cnt;
    int          last_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare process: one expected record per driven cycle.
    initial begin
        logic [33:0] e;
        run_cnt  = 0;
        last_run = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (waitrequest !== e[33] || err !== e[32] || readdata !== e[31:0]) begin
                    bad++;
                    $display("FAIL cycle @%0t: got wr=%b err=%b rd=%h, expected wr=%b err=%b rd=%h",
                             $time, waitrequest, err, readdata, e[33], e[32], e[31:0]);
                end
            end
            if (waitrequest === 1'b1) begin
                run_cnt++;
            end else begin
                if (run_cnt != 0) last_run = run_cnt;
                run_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic wr_e);
        exp_q.push_back({wr_e, err_m, rd_m});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            read  = 1'b0;
            write = 1'b0;
            stall = 1'b0;
            push(1'b0);
            tick();
        end
    endtask

    // Full transfer: accept cycle, LAT wait cycles, `stalls` extra wait
    // cycles held by stall once the countdown is spent, then one response.
    task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] data, input int stalls);
        logic in_rng;
        int   idx;
        in_rng = ({1'b0, addr} >= {1'b0, BASE}) &&
                 ({1'b0, addr} < ({1'b0, BASE} + 33'(4 * DEPTH)));
        idx    = in_rng ? int'((addr - BASE) >> 2) : 0;
        for (int k = 0; k <= LAT + stalls + 1; k++) begin
            read       = rd;
            write      = wr;
            address    = addr;
            byteenable = be;
            writedata  = data;
            stall      = (k >= LAT) && (k < LAT + stalls);
            if (k == LAT + stalls + 1) begin
                if (!in_rng) err_m = 1'b1;
                if (rd) rd_m = in_rng ? mem_m[idx] : 32'h0;
                push(1'b0);
            end else begin
                push(1'b1);
            end
            tick();
        end
        if (wr && in_rng) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_m[idx][8*b +: 8] = data[8*b +: 8];
        end
        read  = 1'b0;
        write = 1'b0;
        stall = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        rd_m  = 32'h0;
        err_m = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        rst_n      = 1'b0;
        address    = 32'h0;
        read       = 1'b0;
        write      = 1'b0;
        byteenable = 4'h0;
        writedata  = 32'h0;
        stall      = 1'b0;
        tick();

        // Reset state
        idle(2);
        check("reset_wr", {31'h0, waitrequest}, 32'h0);
        check("reset_rd", readdata, 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Full-word write then back-to-back read
        do_xfer(1'b0, 1'b1, 32'hBFC00010, 4'hF, 32'hDEADBEEF, 0);
        check("write_latency", last_run, 3);
        do_xfer(1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 0);
        check("read_latency", last_run, 3);
        check("read_deadbeef", readdata, 32'hDEADBEEF);

        // Partial byte-lane write
        do_xfer(1'b0, 1'b1, 32'hBFC00014, 4'hF, 32'h11223344, 0);
        do_xfer(1'b0, 1'b1, 32'hBFC00014, 4'b0011, 32'hAABBCCDD, 0);
        do_xfer(1'b1, 1'b0, 32'hBFC00014, 4'b0000, 32'h0, 0);
        check("read_lanes", readdata, 32'h1122CCDD);
        idle(2);

        // Stalled read
        do_xfer(1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 4);
        check("stall_latency", last_run, 7);
        check("stall_err", {31'h0, err}, 32'h0);

        // byteenable 0 leaves memory alone; top word; readdata held after writes
        do_xfer(1'b0, 1'b1, 32'hBFC00014, 4'h0, 32'hFFFFFFFF, 0);
        do_xfer(1'b0, 1'b1, 32'hBFC000FC, 4'hF, 32'h0BADF00D, 0);
        check("hold_after_write", readdata, 32'hDEADBEEF);
        do_xfer(1'b1, 1'b0, 32'hBFC00014, 4'hF, 32'h0, 0);
        do_xfer(1'b1, 1'b0, 32'hBFC000FC, 4'hF, 32'h0, 0);
        check("read_top", readdata, 32'h0BADF00D);
        idle(1);

        // Both read and write high: refused, err set, memory unchanged
        read       = 1'b1;
        write      = 1'b1;
        address    = 32'hBFC00010;
        byteenable = 4'hF;
        writedata  = 32'h01010101;
        push(1'b0);
        tick();
        err_m = 1'b1;
        idle(1);
        check("both_err", {31'h0, err}, 32'h1);
        do_xfer(1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 0);
        check("both_nochange", readdata, 32'hDEADBEEF);

        // Address change mid-WAIT aborts without writing
        read       = 1'b0;
        write      = 1'b1;
        address    = 32'hBFC00018;
        byteenable = 4'hF;
        writedata  = 32'h55555555;
        push(1'b1);
        tick();
        address = 32'hBFC0001C;
        push(1'b1);
        tick();
        err_m = 1'b1;
        idle(2);
        check("abort_idle_wr", {31'h0, waitrequest}, 32'h0);
        do_xfer(1'b1, 1'b0, 32'hBFC00018, 4'hF, 32'h0, 0);
        check("abort_nowrite_a", readdata, 32'h0);
        do_xfer(1'b1, 1'b0, 32'hBFC0001C, 4'hF, 32'h0, 0);
        check("abort_nowrite_b", readdata, 32'h0);

        // Reset during WAIT of a write discards it
        do_xfer(1'b0, 1'b1, 32'hBFC00020, 4'hF, 32'hCAFEF00D, 0);
        do_xfer(1'b1, 1'b0, 32'hBFC00020, 4'hF, 32'h0, 0);
        check("pre_reset_read", readdata, 32'hCAFEF00D);
        read       = 1'b0;
        write      = 1'b1;
        address    = 32'hBFC00020;
        byteenable = 4'hF;
        writedata  = 32'h12345678;
        push(1'b1);
        tick();
        push(1'b1);
        tick();
        rst_n = 1'b0;
        write = 1'b0;
        err_m = 1'b0;
        rd_m  = 32'h0;
        #1;
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_wr", {31'h0, waitrequest}, 32'h0);
        push(1'b0);
        tick();
        rst_n = 1'b1;
        idle(1);
        do_xfer(1'b1, 1'b0, 32'hBFC00020, 4'hF, 32'h0, 0);
        check("rst_word_kept", readdata, 32'hCAFEF00D);

        // Out of range: write dropped (no wrap onto word 0), read returns 0
        do_xfer(1'b0, 1'b1, 32'hBFC00100, 4'hF, 32'h77777777, 0);
        check("oor_write_err", {31'h0, err}, 32'h1);
        do_xfer(1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'h0, 0);
        check("oor_no_alias", readdata, 32'h0);
        do_xfer(1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 0);
        do_xfer(1'b1, 1'b0, 32'h00000000, 4'hF, 32'h0, 0);
        check("oor_read_zero", readdata, 32'h0);
        check("oor_read_latency", last_run, 3);
        do_xfer(1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, 0);
        check("after_oor_read", readdata, 32'hDEADBEEF);
        check("err_sticky", {31'h0, err}, 32'h1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, RAM size in 32-bit words.
REQ-002 SHALL have parameter BASE, default 32'hBFC00000, byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..15, base wait cycles per transfer.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have port address  input  32  byte address from the CPU; bits [1:0] ignored.
REQ-007 SHALL have port read  input  1  read request.
REQ-008 SHALL have port write  input  1  write request.
REQ-009 SHALL have port byteenable  input  4  lane enables; bit n covers writedata[8n+7:8n].
REQ-010 SHALL have port writedata  input  32  store data.
REQ-011 SHALL have port stall  input  1  test hook; extends WAIT while high.
REQ-012 SHALL have port waitrequest  output  1  high = transfer not yet complete.
REQ-013 SHALL have port readdata  output  32  load data, valid while RESP.
REQ-014 SHALL have port err  output  1  sticky protocol/range error flag.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; one transfer in flight at a time.
REQ-016 IDLE: a request is exactly one of read/write high; it SHALL latch address, byteenable, writedata and op, load cnt=LATENCY-1, and go to WAIT.
REQ-017 waitrequest SHALL be high combinationally in IDLE while a request is present, and high throughout WAIT.
REQ-018 WAIT: if cnt==0 and stall low, go to RESP; else if cnt!=0, decrement cnt; stall high holds cnt.
REQ-019 Latency: waitrequest-high cycles per transfer SHALL equal 1+LATENCY plus the number of stall-high cycles spent in WAIT with cnt==0.
REQ-020 On WAIT->RESP for a read, readdata SHALL load mem[(addr-BASE)>>2] as a full word, independent of byteenable.
REQ-021 RESP SHALL last exactly one cycle with waitrequest low, then return to IDLE.
REQ-022 A write SHALL commit at the clock edge ending RESP, updating only enabled byte lanes; byteenable 4'b0000 SHALL leave memory unchanged.
REQ-023 readdata SHALL hold its last value outside RESP and after writes.
REQ-024 Back-to-back: a request present in the cycle after RESP SHALL be accepted with no idle gap.
REQ-025 Out of range (addr < BASE or addr >= BASE+4*DEPTH): a read SHALL return 32'h0, a write SHALL be dropped, err SHALL set; timing SHALL match REQ-019.
REQ-026 read and write both high in IDLE SHALL not be accepted: waitrequest low, no memory change, err set.
REQ-027 In WAIT, a change of address, op or byteenable, or both read/write low, SHALL abort to IDLE with no memory change and set err.
REQ-028 err SHALL clear only on reset.
REQ-029 Memory contents SHALL not be reset; they are initialised to zero at elaboration.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, cnt=0, readdata=32'h0, err=0; waitrequest SHALL then follow REQ-017.
REQ-031 Reset during WAIT or RESP SHALL discard the pending write; memory SHALL be unchanged.
REQ-032 The first request SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-033 Write 32'hDEADBEEF to 32'hBFC00010, byteenable 4'hF, LATENCY=2, stall=0 -> waitrequest high 3 cycles, low 1; read back -> readdata 32'hDEADBEEF.
REQ-034 Word holds 32'h11223344; write 32'hAABBCCDD with byteenable 4'b0011 -> read returns 32'h1122CCDD.
REQ-035 Read with stall high for 4 cycles once cnt==0, LATENCY=2 -> waitrequest high 7 cycles, err stays 0.
REQ-036 Read of 32'h00000000 -> readdata 32'h0, err=1 after RESP; a following in-range read still completes normally and err stays 1.
REQ-037 Both read and write high -> waitrequest 0, err=1, memory unchanged; address changed mid-WAIT -> abort, err=1, no write.
REQ-038 rst_n pulsed low during WAIT of a write to 32'hBFC00020 -> state IDLE, word unchanged, err=0, readdata=32'h0.
